// File: rtl/divider_pkg.sv
// Shared definitions for the divider84 datapath and its shift-add reconstruction block.
package divider_pkg;

    localparam int QW = 8;
    localparam int DW = 4;
    localparam int PW = QW + DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divmul_recon84.sv
// Rebuilds numerator = quotient*denominator + remainder with one shift-add step per cycle.
// start is sampled only in IDLE; done pulses one cycle with product and num_ok valid.
module divmul_recon84
    import divider_pkg::*;
#(
    parameter int QW = divider_pkg::QW,
    parameter int DW = divider_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [QW-1:0]        quotient,
    input  logic [DW-1:0]        denominator,
    input  logic [DW-1:0]        remainder,
    output logic                 busy,
    output logic                 done,
    output logic [QW+DW-1:0]     product,
    output logic                 num_ok
);

    localparam int PW = QW + DW;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    state_e          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   q_r;
    logic [DW-1:0]   d_r;
    logic [DW-1:0]   d_cap;
    logic [DW-1:0]   r_cap;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc_next;
    logic            legal_next;

    // The accumulator is PW bits wide, so the largest sum never carries out.
    assign acc_next   = d_r[0] ? acc + q_r : acc;
    assign legal_next = (acc_next[PW-1:QW] == '0) && (d_cap != '0) && (r_cap < d_cap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            num_ok  <= 1'b0;
            acc     <= '0;
            q_r     <= '0;
            d_r     <= '0;
            d_cap   <= '0;
            r_cap   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_r   <= {{DW{1'b0}}, quotient};
                        d_r   <= denominator;
                        d_cap <= denominator;
                        r_cap <= remainder;
                        acc   <= {{QW{1'b0}}, remainder};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    q_r <= q_r << 1;
                    d_r <= d_r >> 1;
                    cnt <= cnt + 1'b1;
                    // Final iteration: publish the result alongside the DONE transition.
                    if (cnt == CW'(DW - 1)) begin
                        product <= acc_next;
                        num_ok  <= legal_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
